ram_seq: RTL and testbench

Parametrised DRAM sequencer for the 68000-side RAM path, successor to the fixed-timing RAS/CAS controller. It sits between the bus-cycle decoder (RAM select, AS tracking) and the DRAM pins. It multiplexes row and column addresses, generates nRAS/nCAS/write strobes with configurable RAS and precharge widths, and owns its own refresh timer. Refresh requests queue in a pending counter, so refresh defers behind RAM accesses until a programmable urgency threshold.

---
 rtl/ram_pkg.sv | 23 ++
 rtl/ram_reftimer.sv | 54 +++++
 rtl/ram_seq.sv | 188 ++++++++++++++++++
 tb/tb_ram_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the 68000-side DRAM sequencer.
// Build option RAM_CBR_EN selects CAS-before-RAS refresh instead of RAS-only.
package ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    HOLD,
    PRE,
    REF_CAS,
    REF_RAS,
    REF_PRE
  } ram_state_t;

  localparam int RW_DEF = 12;

  // 15.6 us refresh interval at a 25 MHz CLK -> 390 cycles per tick
  localparam int CLK_MHZ = 25;
  localparam int REF_NS = 15_600;
  localparam int REF_DIV_25M = CLK_MHZ * REF_NS / 1000;

endpackage

// File: rtl/ram_reftimer.sv
// Refresh tick divider with saturating pending-refresh counter.
// RefOvf is sticky until reset; RefTake retires one pending refresh.
module ram_reftimer #(
  parameter int  REF_DIV = 390,
  parameter int  REF_MAX = 4,
  localparam int PW      = $clog2(REF_MAX + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          RefTake,
  output logic [PW-1:0] RefPend,
  output logic [PW-1:0] RefPendNext,
  output logic          RefOvf
);

  localparam int TW = $clog2(REF_DIV);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          tick;

  always_comb begin
    tick   = (tcnt_q == '0);
    tcnt_d = tick ? TW'(REF_DIV - 1) : tcnt_q - 1'b1;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (tick && pend_q == PW'(REF_MAX))
      ovf_d = 1'b1;
    // a tick and a take in the same cycle cancel out
    unique case ({tick, RefTake})
      2'b10: if (pend_q != PW'(REF_MAX)) pend_d = pend_q + 1'b1;
      2'b01: pend_d = pend_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tcnt_q <= TW'(REF_DIV - 1);
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign RefPend     = pend_q;
  assign RefPendNext = pend_d;
  assign RefOvf      = ovf_q;

endmodule

// File: rtl/ram_seq.sv
// DRAM sequencer: row/column mux, RAS/CAS/WE strobes, deferred refresh.
// RAM_CBR_EN defined: CAS-before-RAS refresh; undefined: RAS-only refresh.
module ram_seq
  import ram_pkg::*;
#(
  parameter int  RW      = RW_DEF,
  parameter int  RAS_CYC = 2,
  parameter int  PRE_CYC = 2,
  parameter int  REF_DIV = REF_DIV_25M,
  parameter int  REF_MAX = 4,
  parameter int  REF_URG = 2,
  localparam int PW      = $clog2(REF_MAX + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          AccReq,
  input  logic          AccEnd,
  input  logic [2*RW-1:0] A,
  input  logic          nWE,
  input  logic          nLDS,
  input  logic          nUDS,
  output logic          Ready,
  output logic [RW-1:0] RA,
  output logic          nRAS,
  output logic          nCAS,
  output logic          nLWE,
  output logic          nUWE,
  output logic [PW-1:0] RefPend,
  output logic          RefOvf
);

  localparam int CMAX = (RAS_CYC > PRE_CYC) ? RAS_CYC : PRE_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RAS_LD = CW'(RAS_CYC - 1);
  localparam logic [CW-1:0] PRE_LD = CW'(PRE_CYC - 1);
`ifdef RAM_CBR_EN
  localparam ram_state_t REF_GO = REF_CAS;
`else
  localparam ram_state_t REF_GO = REF_RAS;
`endif

  ram_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          take, urg;
  logic [PW-1:0] pend_d;
  logic          ready_q, ready_d;
  logic          ras_q, ras_d;
  logic          cas_q, cas_d;
  logic          lwe_q, lwe_d;
  logic          uwe_q, uwe_d;
  logic [RW-1:0] ra_q, ra_d;

  ram_reftimer #(
    .REF_DIV (REF_DIV),
    .REF_MAX (REF_MAX)
  ) u_reftimer (
    .CLK         (CLK),
    .nRST        (nRST),
    .RefTake     (take),
    .RefPend     (RefPend),
    .RefPendNext (pend_d),
    .RefOvf      (RefOvf)
  );

  assign urg = (RefPend >= PW'(REF_URG));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (urg || (!AccReq && RefPend != '0)) begin
          state_d = REF_GO;
          cnt_d   = RAS_LD;
          take    = 1'b1;
        end else if (AccReq) begin
          state_d = ROW;
        end
      end
      ROW: state_d = COL;
      COL, HOLD: begin
        if (AccEnd) begin
          state_d = PRE;
          cnt_d   = PRE_LD;
        end else begin
          state_d = HOLD;
        end
      end
      REF_CAS: state_d = REF_RAS;
      REF_RAS: begin
        if (cnt_q == '0) begin
          state_d = REF_PRE;
          cnt_d   = PRE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PRE, REF_PRE: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_d = (state_d == IDLE) && !(pend_d >= PW'(REF_URG));

`ifndef RAM_CBR_EN
  logic [RW-1:0] row_q, row_d;

  assign row_d = (state_q == REF_RAS && cnt_q == '0) ? row_q + 1'b1 : row_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) row_q <= '0;
    else       row_q <= row_d;
  end
`endif

  // strobes are registered from the current state, one cycle behind it
  always_comb begin
    ras_d = 1'b1;
    cas_d = 1'b1;
    lwe_d = 1'b1;
    uwe_d = 1'b1;
    ra_d  = '0;
    unique case (state_q)
      ROW: begin
        ras_d = 1'b0;
        ra_d  = A[2*RW-1:RW];
      end
      COL: begin
        ras_d = 1'b0;
        cas_d = 1'b0;
        ra_d  = A[RW-1:0];
        lwe_d = !(!nLDS && !nWE);
        uwe_d = !(!nUDS && !nWE);
      end
      HOLD: begin
        ras_d = ras_q;
        cas_d = cas_q;
        lwe_d = lwe_q;
        uwe_d = uwe_q;
        ra_d  = ra_q;
      end
      REF_CAS: cas_d = 1'b0;
      REF_RAS: begin
        ras_d = 1'b0;
`ifdef RAM_CBR_EN
        cas_d = 1'b0;
`else
        ra_d  = row_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      ras_q   <= 1'b1;
      cas_q   <= 1'b1;
      lwe_q   <= 1'b1;
      uwe_q   <= 1'b1;
      ra_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      ras_q   <= ras_d;
      cas_q   <= cas_d;
      lwe_q   <= lwe_d;
      uwe_q   <= uwe_d;
      ra_q    <= ra_d;
    end
  end

  assign Ready = ready_q;
  assign nRAS  = ras_q;
  assign nCAS  = cas_q;
  assign nLWE  = lwe_q;
  assign nUWE  = uwe_q;
  assign RA    = ra_q;

endmodule

// File: tb/tb_ram_seq.sv
// Directed bench for ram_seq with a scoreboard of expected DRAM accesses.
// Runs with REF_DIV = 8 so refresh activity overlaps every scenario.
module tb_ram_seq;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        AccReq, AccEnd;
  logic [23:0] A;
  logic        nWE, nLDS, nUDS;
  logic        Ready;
  logic [11:0] RA;
  logic        nRAS, nCAS, nLWE, nUWE;
  logic [2:0]  RefPend;
  logic        RefOvf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [11:0] row;
    logic [11:0] col;
    logic        lwe;
    logic        uwe;
  } acc_t;

  acc_t        sbq[$];
  logic [11:0] rowq[$];

  localparam int P_RAS = 0;
  localparam int P_CAS = 1;
  localparam int P_RDY = 2;
  localparam int P_P0  = 3;

  ram_seq #(
    .RW      (12),
    .RAS_CYC (2),
    .PRE_CYC (2),
    .REF_DIV (8),
    .REF_MAX (4),
    .REF_URG (2)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .AccReq  (AccReq),
    .AccEnd  (AccEnd),
    .A       (A),
    .nWE     (nWE),
    .nLDS    (nLDS),
    .nUDS    (nUDS),
    .Ready   (Ready),
    .RA      (RA),
    .nRAS    (nRAS),
    .nCAS    (nCAS),
    .nLWE    (nLWE),
    .nUWE    (nUWE),
    .RefPend (RefPend),
    .RefOvf  (RefOvf)
  );

  always #5 CLK = ~CLK;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      P_RAS:   return nRAS;
      P_CAS:   return nCAS;
      P_RDY:   return Ready;
      default: return RefPend == 3'd0;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int sel, input logic val,
                          input int lim, output bit ok);
    int n = 0;
    while (probe(sel) !== val && n < lim) begin
      step();
      n++;
    end
    tests++;
    ok = (probe(sel) === val);
    assert (probe(sel) === val) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b within %0d cycles",
             tag, probe(sel), val, lim);
    end
  endtask

  task automatic start_acc(input logic [11:0] r, input logic [11:0] c,
                           input logic we, input logic lds, input logic uds,
                           input logic elwe, input logic euwe);
    acc_t e;
    A      = {r, c};
    nWE    = we;
    nLDS   = lds;
    nUDS   = uds;
    AccReq = 1'b1;
    e.row  = r;
    e.col  = c;
    e.lwe  = elwe;
    e.uwe  = euwe;
    sbq.push_back(e);
  endtask

  // waits for acceptance, then checks ROW at N+1 and COL at N+2
  task automatic check_access(input string tag);
    acc_t e;
    bit   ok;
    wait_sig({tag, "_ready"}, P_RDY, 1'b1, 60, ok);
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
      return;
    end
    e = sbq.pop_front();
    step();
    chk({tag, "_busy"}, Ready, 1'b0);
    step();
    chk({tag, "_row_ras"}, nRAS, 1'b0);
    chk({tag, "_row_cas"}, nCAS, 1'b1);
    chk({tag, "_row_ra"}, RA, e.row);
    step();
    chk({tag, "_col_ras"}, nRAS, 1'b0);
    chk({tag, "_col_cas"}, nCAS, 1'b0);
    chk({tag, "_col_ra"}, RA, e.col);
    chk({tag, "_lwe"}, nLWE, e.lwe);
    chk({tag, "_uwe"}, nUWE, e.uwe);
  endtask

  initial begin
    int   n, hi, refs;
    logic prev;
    logic [2:0] maxp;
    bit   ok;

    nRST = 1'b0;
    AccReq = 1'b0;
    AccEnd = 1'b0;
    A = '0;
    nWE = 1'b1;
    nLDS = 1'b1;
    nUDS = 1'b1;
    step(2);
    chk("rst_ras", nRAS, 1'b1);
    chk("rst_cas", nCAS, 1'b1);
    chk("rst_lwe", nLWE, 1'b1);
    chk("rst_uwe", nUWE, 1'b1);
    chk("rst_ra", RA, 12'h000);
    chk("rst_ready", Ready, 1'b1);
    chk("rst_pend", RefPend, 3'd0);
    chk("rst_ovf", RefOvf, 1'b0);

    // idle bus: first tick after 8 edges, refresh on the next
    nRST = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (RefPend !== 3'd1 && n < 20);
    chk("tick_cycle", n, 8);
    step();
    chk("ref_take", RefPend, 3'd0);
    chk("ref_busy", Ready, 1'b0);
    step();
`ifdef RAM_CBR_EN
    chk("cbr_cas_first", nCAS, 1'b0);
    chk("cbr_ras_high", nRAS, 1'b1);
    step();
    chk("cbr_ras", nRAS, 1'b0);
    chk("cbr_cas", nCAS, 1'b0);
    chk("cbr_ra", RA, 12'h000);
`else
    chk("ror_ras", nRAS, 1'b0);
    chk("ror_cas", nCAS, 1'b1);
    chk("ror_ra", RA, 12'h000);
    step();
    chk("ror_ras2", nRAS, 1'b0);
`endif
    step();
    chk("ref_pre", nRAS, 1'b1);

    // basic write to the low byte
    start_acc(12'h0A5, 12'h13C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_access("acc1");
    AccEnd = 1'b1;
    step();
    chk("acc1_end_hold", nCAS, 1'b0);
    chk("acc1_end_lwe", nLWE, 1'b0);
    step();
    chk("acc1_end_ras", nRAS, 1'b1);
    chk("acc1_end_cas", nCAS, 1'b1);
    chk("acc1_end_lwe1", nLWE, 1'b1);
    AccReq = 1'b0;
    AccEnd = 1'b0;
    chk("acc1_ovf", RefOvf, 1'b0);

    // long access defers refresh; queued refreshes run before the next one
    start_acc(12'h3FF, 12'h001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_access("acc2");
    hi = 0;
    maxp = 3'd0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (nCAS !== 1'b0) hi++;
      if (RefPend > maxp) maxp = RefPend;
    end
    chk("acc2_uninterrupted", hi, 0);
    chk("acc2_pend_ge2", maxp >= 3'd2, 1'b1);
    start_acc(12'h800, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    AccEnd = 1'b1;
    step();
    AccEnd = 1'b0;
    refs = 0;
    prev = nRAS;
    n = 0;
    while (Ready !== 1'b1 && n < 60) begin
      step();
      n++;
      if (prev === 1'b1 && nRAS === 1'b0) refs++;
      prev = nRAS;
    end
    chk("acc2_ready_back", Ready, 1'b1);
    chk("acc2_refs_b2b", refs >= 2, 1'b1);
    chk("acc2_pend_low", RefPend < 3'd2, 1'b1);
    check_access("acc3");
    AccEnd = 1'b1;
    step();
    AccReq = 1'b0;
    step();
    AccEnd = 1'b0;

    // very long access saturates the pending count
    start_acc(12'h123, 12'h456, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_access("acc4");
    maxp = 3'd0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (RefPend > maxp) maxp = RefPend;
    end
    chk("sat_max", maxp, 3'd4);
    chk("sat_pend", RefPend, 3'd4);
    chk("sat_ovf", RefOvf, 1'b1);
    chk("sat_cas", nCAS, 1'b0);
    AccEnd = 1'b1;
    step();
    AccReq = 1'b0;
    step();
    AccEnd = 1'b0;
    wait_sig("drain_pend0", P_P0, 1'b1, 200, ok);
    chk("drain_ovf", RefOvf, 1'b1);

    // reset in the middle of an access
    start_acc(12'h7AA, 12'h055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_access("acc5");
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_ras", nRAS, 1'b1);
    chk("arst_cas", nCAS, 1'b1);
    chk("arst_lwe", nLWE, 1'b1);
    chk("arst_ovf", RefOvf, 1'b0);
    AccReq = 1'b0;
    #2;
    nRST = 1'b1;
    step();
    chk("arst_ready", Ready, 1'b1);
    chk("arst_pend", RefPend, 3'd0);
    chk("arst_ras2", nRAS, 1'b1);

`ifdef RAM_CBR_EN
    for (int i = 0; i < 4; i++) rowq.push_back(12'h000);
`else
    for (int i = 0; i <= 4096; i++) rowq.push_back(12'(i));
`endif
    while (rowq.size() != 0) begin
      logic [11:0] er;
      er = rowq.pop_front();
      wait_sig("rowseq_low", P_RAS, 1'b0, 30, ok);
      if (!ok) break;
      chk("rowseq_ra", RA, er);
`ifdef RAM_CBR_EN
      chk("rowseq_cas", nCAS, 1'b0);
`else
      chk("rowseq_cas", nCAS, 1'b1);
`endif
      wait_sig("rowseq_high", P_RAS, 1'b1, 10, ok);
      if (!ok) break;
    end
    chk("rowseq_ovf", RefOvf, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
